instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage directly upstream of the instruction memory and downstream-facing toward decode. Owns the program counter, drives it to the instruction memory's PC input, and captures the returned 32-bit instruction code into an IF/ID output register. The output uses a valid/ready handshake, so decode can stall fetch. The block also accepts a redirect for branches and jumps, stops cleanly at the end of the 32-byte program image, and flags the custom CONVOL opcode for the downstream convolution path.

## Interface
- IMEM_BYTES, 32: instruction memory size in bytes; multiple of 4.
- RESET_PC, 0: PC loaded on reset; word aligned.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- pc_out  out  32  current fetch address to instruction memory PC input.
- instr_in  in  32  instruction code returned combinationally for pc_out.
- out_valid  out  1  IF/ID register holds an instruction.
- out_ready  in  1  decode accepts the instruction this cycle.
- out_instr  out  32  registered instruction word.
- out_pc  out  32  address out_instr was fetched from.
- out_is_convol  out  1  registered flag: out_instr[6:0] == 7'b0001011 (custom-0, CONVOL).
- redirect_valid  in  1  load new PC and flush the IF/ID register.
- redirect_pc  in  32  redirect target.
- halted  out  1  fetch stopped and IF/ID register empty.
- fetch_count  out  16  number of accepted handshakes, saturating.

## Operation
- State machine states are FETCH and HALT. Reset enters FETCH with pc=RESET_PC.
- On reset, out_valid=0, out_instr=0, out_pc=0, out_is_convol=0, halted=0, and fetch_count=0. pc_out equals RESET_PC.
- pc_out is driven from the pc register without combinational dependence on any input.
- Capture condition: state==FETCH and (!out_valid or out_ready).
- On capture:
  - out_instr<=instr_in, out_pc<=pc, and out_is_convol<=(instr_in[6:0]==7'b0001011).
  - out_valid<=1 and pc<=pc+4.
- End of image: if pc+4 >= IMEM_BYTES at capture, the next state is HALT. pc does not wrap. pc is frozen at IMEM_BYTES.
- HALT state:
  - No captures.
  - out_valid holds until out_ready, then clears.
  - halted = (state==HALT) && !out_valid.
- Stall: while out_valid && !out_ready, all IF/ID fields and pc hold.
- Redirect has the highest priority and applies in either state:
  - Target is redirect_pc with bits [1:0] forced to 0.
  - pc<=target and out_valid<=0 (flush). There is no capture that cycle.
  - Next state is FETCH if target < IMEM_BYTES, else HALT.
- fetch_count increments on each cycle with out_valid && out_ready, including a cycle that also carries a redirect. It saturates at 16'hFFFF.
- pc arithmetic is 32-bit unsigned. The comparison against IMEM_BYTES is unsigned.

## Timing
- Fetch latency: an instruction at pc appears on out_instr one rising edge after pc_out=pc, provided the capture condition holds.
- Throughput: one instruction per cycle while out_ready is held at 1.
- After reset deasserts, the first rising edge captures RESET_PC (out_valid=1 after that edge).
- A redirect in cycle N:
  - out_valid=0 after edge N.
  - pc_out=target after edge N.
  - The target instruction is valid after edge N+1.
- Assertion of reset at any time, including mid-stall or mid-redirect, clears outputs asynchronously without waiting for clk. Deassertion is assumed synchronous to clk by the system.
- halted rises on the edge where the last valid instruction is accepted in HALT, or on the redirect edge when the target is out of range.

## Test plan
- Reset, then out_ready=1 with an 8-word image:
  - out_pc takes 0x00,0x04,…,0x1C on 8 consecutive cycles.
  - Then out_valid=0 and halted=1.
  - fetch_count=8, pc_out=0x20.
- Backpressure, out_ready=0 for 3 cycles while out_pc=0x08:
  - out_instr, out_pc and pc_out=0x0C hold.
  - On out_ready=1, the next out_pc is 0x0C and no word is skipped or duplicated.
- Redirect_valid with redirect_pc=0x0E while out_valid=1, out_ready=0:
  - out_valid=0 next cycle.
  - pc_out=0x0C, then out_pc=0x0C.
  - fetch_count unchanged.
- Redirect to 0x40:
  - Next cycle state is HALT, halted=1, out_valid stays 0.
  - A later redirect to 0x04 resumes with out_pc=0x04.
- CONVOL flag:
  - instr_in=0x010C0E0B at pc 0 gives out_is_convol=1.
  - Next word 0x413903B3 gives out_is_convol=0.
- reset driven low between edges mid-stream:
  - All outputs read reset values before the next clk edge.
  - After release, fetch restarts at out_pc=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage sitting between the instruction memory and decode. It owns the
// program counter, presents it to the instruction memory, and captures the
// combinationally returned instruction word into an IF/ID register that is
// handed to decode over a valid/ready handshake. Branch/jump redirects flush
// the IF/ID register and reload the PC. Fetch stops cleanly once the last word
// of the program image has been captured, and the custom-0 CONVOL opcode is
// flagged alongside the instruction for the convolution path.
//
// Parameters
//   IMEM_BYTES     instruction memory size in bytes (multiple of 4)
//   RESET_PC       word-aligned PC loaded on reset
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   pc_out         current fetch address to the instruction memory
//   instr_in       instruction word returned for pc_out
//   out_valid      IF/ID register holds an instruction
//   out_ready      decode accepts the instruction this cycle
//   out_instr      registered instruction word
//   out_pc         address out_instr was fetched from
//   out_is_convol  registered flag: out_instr is a CONVOL (custom-0) opcode
//   redirect_valid load redirect_pc and flush the IF/ID register
//   redirect_pc    redirect target (low two bits ignored)
//   halted         fetch stopped and IF/ID register empty
//   fetch_count    saturating count of accepted handshakes
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int unsigned IMEM_BYTES = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_out,
  input  logic [31:0] instr_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_is_convol,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);
  localparam logic [6:0]  OPC_CONVOL = 7'b0001011;
  localparam logic [15:0] COUNT_MAX  = 16'hFFFF;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  // Registered state
  state_t      state_q,         state_d;
  logic [31:0] pc_q,            pc_d;
  logic        out_valid_q,     out_valid_d;
  logic [31:0] out_instr_q,     out_instr_d;
  logic [31:0] out_pc_q,        out_pc_d;
  logic        out_is_convol_q, out_is_convol_d;
  logic        halted_q,        halted_d;
  logic [15:0] fetch_count_q,   fetch_count_d;

  // Derived control
  logic [31:0] redirect_target;
  logic        target_in_range;
  logic [32:0] pc_inc;
  logic        end_of_image;
  logic        handshake;
  logic        capture;

  // Low two bits are dropped so the PC can never become misaligned.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign target_in_range = (redirect_target < IMEM_LIMIT);

  // One extra bit keeps the end-of-image test correct even for a PC at the
  // very top of the 32-bit address space.
  assign pc_inc       = {1'b0, pc_q} + 33'd4;
  assign end_of_image = (pc_inc >= {1'b0, IMEM_LIMIT});

  assign handshake = out_valid_q && out_ready;
  assign capture   = (state_q == FETCH) && (!out_valid_q || out_ready);

  // -------------------------------------------------------------------------
  // Next-state logic. Redirect beats capture; in HALT only the drain of the
  // final IF/ID entry can happen.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    out_valid_d     = out_valid_q;
    out_instr_d     = out_instr_q;
    out_pc_d        = out_pc_q;
    out_is_convol_d = out_is_convol_q;

    if (redirect_valid) begin
      pc_d        = redirect_target;
      out_valid_d = 1'b0;
      state_d     = target_in_range ? FETCH : HALT;
    end else if (capture) begin
      out_instr_d     = instr_in;
      out_pc_d        = pc_q;
      out_is_convol_d = (instr_in[6:0] == OPC_CONVOL);
      out_valid_d     = 1'b1;
      // Past the last word the PC parks at IMEM_BYTES rather than wrapping.
      pc_d            = pc_inc[31:0];
      state_d         = end_of_image ? HALT : FETCH;
    end else if (handshake) begin
      // Only reachable in HALT: decode drains the final instruction.
      out_valid_d = 1'b0;
    end
  end

  // A handshake is counted even when a redirect flushes in the same cycle,
  // since decode has already taken the word.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (handshake && (fetch_count_q != COUNT_MAX)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  // halted is registered from next-state values so it rises on the same
  // edge that drains the last entry or takes an out-of-range redirect.
  always_comb begin
    halted_d = (state_d == HALT) && !out_valid_d;
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= FETCH;
      pc_q            <= RESET_PC;
      out_valid_q     <= 1'b0;
      out_instr_q     <= 32'h0;
      out_pc_q        <= 32'h0;
      out_is_convol_q <= 1'b0;
      halted_q        <= 1'b0;
      fetch_count_q   <= 16'h0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      out_valid_q     <= out_valid_d;
      out_instr_q     <= out_instr_d;
      out_pc_q        <= out_pc_d;
      out_is_convol_q <= out_is_convol_d;
      halted_q        <= halted_d;
      fetch_count_q   <= fetch_count_d;
    end
  end

  // Every output comes straight from a register; pc_out has no input path.
  assign pc_out        = pc_q;
  assign out_valid     = out_valid_q;
  assign out_instr     = out_instr_q;
  assign out_pc        = out_pc_q;
  assign out_is_convol = out_is_convol_q;
  assign halted        = halted_q;
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// Testbench for instruction_fetch_unit: directed scenarios from the block's
// test plan, randomized redirect/backpressure/reset traffic, and a long run
// to saturate fetch_count. Expected values come from a transaction-level
// reference model of the fetch stage (a PC, a one-entry output slot, a halt
// flag and a counter) plus constants taken directly from the behaviour
// description.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam int unsigned IMEM_BYTES = 32;
  localparam logic [31:0] RESET_PC   = 32'h0;

  logic        clk;
  logic        reset;
  logic [31:0] pc_out;
  logic [31:0] instr_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_is_convol;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic [15:0] fetch_count;

  instruction_fetch_unit #(
    .IMEM_BYTES (IMEM_BYTES),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_out         (pc_out),
    .instr_in       (instr_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_is_convol  (out_is_convol),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image; out-of-range reads return a recognisable filler.
  logic [31:0] imem [8];

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr < IMEM_BYTES) return imem[addr[4:2]];
    return 32'hDEAD_BEEF;
  endfunction

  always_comb instr_in = mem_word(pc_out);

  // ---------------------------------------------------------------------------
  // Reference model: one output slot, a PC, a halt flag, a counter.
  // ---------------------------------------------------------------------------
  logic [31:0] m_pc;
  logic        m_halt;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_out_pc;
  logic        m_conv;
  logic [15:0] m_count;

  int n_compared;
  int n_mismatched;
  bit verbose;

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_halt   = 1'b0;
    m_valid  = 1'b0;
    m_instr  = 32'h0;
    m_out_pc = 32'h0;
    m_conv   = 1'b0;
    m_count  = 16'h0;
  endtask

  task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
    logic [31:0] t;
    if (m_valid && rdy && (m_count != 16'hFFFF)) m_count = m_count + 16'd1;
    if (rv) begin
      t       = {rpc[31:2], 2'b00};
      m_pc    = t;
      m_valid = 1'b0;
      m_halt  = (t >= IMEM_BYTES);
    end else if (!m_halt) begin
      if (!m_valid || rdy) begin
        m_instr  = mem_word(m_pc);
        m_out_pc = m_pc;
        m_conv   = (m_instr[6:0] == 7'h0B);
        m_valid  = 1'b1;
        m_halt   = (longint'(m_pc) + 4 >= longint'(IMEM_BYTES));
        m_pc     = m_pc + 32'd4;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("pc_out",        pc_out,                 m_pc);
    check_eq("out_valid",     32'(out_valid),         32'(m_valid));
    check_eq("out_instr",     out_instr,              m_instr);
    check_eq("out_pc",        out_pc,                 m_out_pc);
    check_eq("out_is_convol", 32'(out_is_convol),     32'(m_conv));
    check_eq("halted",        32'(halted),            32'(m_halt && !m_valid));
    check_eq("fetch_count",   32'(fetch_count),       32'(m_count));
  endtask

  // One clock transaction: drive inputs, clock, advance model, check #1 later.
  task automatic do_cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    model_step(rv, rpc, rdy);
    #1;
    check_all();
    if (verbose)
      $display("cycle rv=%0b rpc=0x%08h rdy=%0b -> pc_out=0x%08h v=%0b out_pc=0x%08h instr=0x%08h cv=%0b h=%0b cnt=%0d",
               rv, rpc, rdy, pc_out, out_valid, out_pc, out_instr, out_is_convol, halted, fetch_count);
  endtask

  // Drop reset between edges and confirm the outputs clear before any edge.
  task automatic async_reset_pulse();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("rst_pc_out", pc_out, RESET_PC);
    check_eq("rst_valid",  32'(out_valid), 32'd0);
    if (verbose) $display("async reset asserted mid-cycle at t=%0t", $time);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    int budget;
    n_compared     = 0;
    n_mismatched   = 0;
    verbose        = 1'b1;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;

    imem[0] = 32'h010C_0E0B;   // CONVOL
    imem[1] = 32'h4139_03B3;
    for (int i = 2; i < 8; i++) imem[i] = $urandom();
    imem[5] = {imem[5][31:7], 7'b0001011};

    // --- reset state ---
    #1;
    model_reset();
    check_all();
    check_eq("reset_pc_out", pc_out, RESET_PC);
    #2;
    reset = 1'b1;

    // --- straight-line fetch of the whole image ---
    for (int i = 0; i < 8; i++) begin
      do_cycle(1'b0, 32'h0, 1'b1);
      check_eq("seq_out_pc", out_pc, 32'(i * 4));
      check_eq("seq_out_instr", out_instr, imem[i]);
    end
    do_cycle(1'b0, 32'h0, 1'b1);
    check_eq("end_valid",  32'(out_valid),   32'd0);
    check_eq("end_halted", 32'(halted),      32'd1);
    check_eq("end_count",  32'(fetch_count), 32'd8);
    check_eq("end_pc_out", pc_out,           32'h20);
    do_cycle(1'b0, 32'h0, 1'b1);
    check_eq("halt_frozen_pc", pc_out, 32'h20);

    // --- backpressure at out_pc 0x08 ---
    do_cycle(1'b1, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 32'h0, 1'b0);
      check_eq("stall_out_pc",    out_pc,    32'h08);
      check_eq("stall_out_instr", out_instr, imem[2]);
      check_eq("stall_pc_out",    pc_out,    32'h0C);
    end
    do_cycle(1'b0, 32'h0, 1'b1);
    check_eq("resume_out_pc", out_pc, 32'h0C);
    check_eq("resume_count",  32'(fetch_count), 32'd11);

    // --- redirect to 0x0E while stalled ---
    do_cycle(1'b1, 32'h0E, 1'b0);
    check_eq("redir_valid",  32'(out_valid),   32'd0);
    check_eq("redir_pc_out", pc_out,           32'h0C);
    check_eq("redir_count",  32'(fetch_count), 32'd11);
    do_cycle(1'b0, 32'h0, 1'b0);
    check_eq("redir_out_pc", out_pc, 32'h0C);
    check_eq("redir_valid2", 32'(out_valid), 32'd1);

    // --- out-of-range redirect, then resume ---
    do_cycle(1'b1, 32'h40, 1'b0);
    check_eq("oor_halted", 32'(halted),    32'd1);
    check_eq("oor_valid",  32'(out_valid), 32'd0);
    do_cycle(1'b0, 32'h0, 1'b1);
    do_cycle(1'b0, 32'h0, 1'b0);
    check_eq("oor_still_halted", 32'(halted),    32'd1);
    check_eq("oor_still_empty",  32'(out_valid), 32'd0);
    do_cycle(1'b1, 32'h04, 1'b0);
    check_eq("resume_halted", 32'(halted), 32'd0);
    do_cycle(1'b0, 32'h0, 1'b0);
    check_eq("resume4_out_pc", out_pc, 32'h04);

    // --- CONVOL flag ---
    do_cycle(1'b1, 32'h0, 1'b0);
    do_cycle(1'b0, 32'h0, 1'b1);
    check_eq("convol_set",   32'(out_is_convol), 32'd1);
    check_eq("convol_instr", out_instr,          32'h010C_0E0B);
    do_cycle(1'b0, 32'h0, 1'b1);
    check_eq("convol_clear", 32'(out_is_convol), 32'd0);
    check_eq("convol_next",  out_instr,          32'h4139_03B3);

    // --- async reset mid-stream, restart from RESET_PC ---
    do_cycle(1'b0, 32'h0, 1'b0);
    async_reset_pulse();
    do_cycle(1'b0, 32'h0, 1'b1);
    check_eq("restart_out_pc", out_pc, RESET_PC);
    check_eq("restart_valid",  32'(out_valid), 32'd1);

    // --- randomized traffic ---
    for (int i = 0; i < 600; i++) begin
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      rv  = ($urandom_range(0, 7) == 0);
      rpc = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 63));
      rdy = ($urandom_range(0, 3) != 0);
      do_cycle(rv, rpc, rdy);
      if ((i % 97) == 50) async_reset_pulse();
    end

    // --- fetch_count saturation ---
    verbose = 1'b0;
    do_cycle(1'b1, 32'h0, 1'b1);
    budget = 0;
    while ((m_count != 16'hFFFF) && (budget < 80000)) begin
      do_cycle(m_valid && (m_out_pc == 32'h1C), 32'h0, 1'b1);
      budget++;
    end
    check_eq("sat_budget_ok", 32'(budget < 80000), 32'd1);
    for (int i = 0; i < 20; i++) do_cycle(m_valid && (m_out_pc == 32'h1C), 32'h0, 1'b1);
    check_eq("sat_count", 32'(fetch_count), 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
